note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Sequencing controller for the synthesizer voice: steps through a 16-entry frequency pattern at a programmable step rate.
- Drives the voice's frequency, volume_square and volume_saw inputs with a per-step linear attack/sustain/release envelope.
- Sits between the host/config logic and the synthesizer; all outputs are registered.

Parameters:
- DEPTH, 16, pattern entries (power of two; index width log2(DEPTH))
- RESET_FREQ, 32'h1B80_0000, frequency output value after reset (440 Hz in Q12.20)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  pattern write strobe
- cfg_addr  in  4  pattern entry index
- cfg_data  in  32  entry frequency, Q12.20; 0 = rest
- wave_sel  in  16  per-entry waveform: 1 = square, 0 = saw
- pattern_len  in  5  active entries; 0 treated as 1, >16 clamped to 16
- step_ticks  in  24  clocks per step; 0 treated as 1
- gate_ticks  in  24  clocks into a step at which release begins
- attack_inc  in  32  envelope increment per clock (Q12.20)
- release_dec  in  32  envelope decrement per clock (Q12.20)
- max_volume  in  32  envelope ceiling (Q12.20)
- start  in  1  begin sequence (pulse)
- stop  in  1  abort sequence (pulse)
- frequency  out  32  to synthesizer frequency, Q12.20
- volume_square  out  32  envelope when entry is square, else 0
- volume_saw  out  32  envelope when entry is saw, else 0
- step_index  out  4  current entry
- busy  out  1  high in any state except IDLE
- done  out  1  one-clock pulse on return to IDLE

Behaviour:
- Reset: state IDLE, env 0, step_index 0, frequency RESET_FREQ, both volumes 0, busy 0, done 0, pattern RAM all 0, tick counter 0.
- frequency is never driven to 0, because the synthesizer divides by it. Rest entries and IDLE hold the last nonzero frequency.
- cfg_we writes RAM[cfg_addr] on the clock edge in any state. Each entry is latched at its step start, so a write to the playing entry takes effect on its next visit.
- States: IDLE, ATTACK, SUSTAIN, RELEASE, REST, DRAIN.
- IDLE + start (no stop) at edge N:
  - At N+1: busy=1, step_index=0, tick=0.
  - Entry nonzero: frequency=entry, ATTACK.
  - Entry zero: REST.
- ATTACK: env += attack_inc each clock, saturating at max_volume (compare at 33 bits, no wrap). On reaching max_volume go to SUSTAIN.
- SUSTAIN: env held.
- Release point: when tick == gate_ticks in ATTACK or SUSTAIN, go to RELEASE.
- RELEASE: env -= release_dec each clock, floor 0. Stays in RELEASE at 0 until the step ends.
- REST: env forced 0, volumes 0.
- Step end: tick == max(step_ticks,1)-1 in any active state.
  - step_index advances; tick resets; the next entry is latched.
  - Next entry nonzero: ATTACK, starting from the current env (legato, no retrigger to 0).
  - gate_ticks >= step_ticks: release never occurs within the step.
- Last step end (step_index == eff_len-1): behaviour per Optional Feature.
- stop (any active state, including simultaneous with start or step end): go to DRAIN. Stop wins over every other event. start while busy is ignored.
- DRAIN: env -= release_dec per clock, floor 0. When env==0, go to IDLE and pulse done for one clock.
- volume_square/volume_saw: env routed by wave_sel[step_index] latched at step start; the other output is 0. Both outputs are 0 in IDLE and REST.
- Config inputs other than cfg_* are sampled continuously. Changing pattern_len mid-run takes effect at the next step-end comparison.
- Reset asserted mid-sequence: immediate return to reset values, RAM cleared.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: after the last step, step_index wraps to 0 and play continues until stop. done pulses only on completion of DRAIN.
- Undefined: after the last step end, go to DRAIN; done pulses when env reaches 0.

Test Plan:
- Reset: hold reset_n=0 → frequency=32'h1B80_0000, volumes=0, busy=0, done=0. Assert mid-ATTACK → same values on the next sample.
- Single note: RAM[0]=440<<20, len=1, step_ticks=100, gate=60, attack_inc=max_volume/10, release_dec=max_volume/10, wave_sel[0]=1, start.
  - N+1: busy=1, frequency=440<<20.
  - volume_square reaches max 10 clocks later; volume_saw stays 0.
  - Release begins at tick 60 and reaches 0 by tick 70.
- Rest entry: RAM={880<<20, 0, 660<<20}, len=3 → frequency holds 880<<20 during step 1 with volumes 0; frequency is 660<<20 at step 2.
- Loop off: len=2, step_ticks=20 → IDLE with a single done pulse after steps 0,1 plus drain. Loop on: step_index sequence 0,1,0,1…, no done until stop.
- start and stop on the same edge from IDLE → DRAIN, then IDLE within 1 clock, done pulse. stop mid-SUSTAIN with release_dec=max/4 → IDLE after 4 clocks.
- Edge config: step_ticks=0 → step advances every clock. pattern_len=0 → only entry 0 plays. pattern_len=31 → indices 0..15. cfg write to entry 0 while it plays → new value heard on its next visit.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: steps a DEPTH-entry frequency pattern with a per-step linear envelope.
// Build option SEQ_LOOP_EN: wrap to entry 0 after the last step instead of draining.
module note_sequencer #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] RESET_FREQ = 32'h1B80_0000,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic [DEPTH-1:0] wave_sel,
  input  logic [AW:0]      pattern_len,
  input  logic [23:0]      step_ticks,
  input  logic [23:0]      gate_ticks,
  input  logic [31:0]      attack_inc,
  input  logic [31:0]      release_dec,
  input  logic [31:0]      max_volume,
  input  logic             start,
  input  logic             stop,
  output logic [31:0]      frequency,
  output logic [31:0]      volume_square,
  output logic [31:0]      volume_saw,
  output logic [AW-1:0]    step_index,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    SUSTAIN = 3'd2,
    RELEASE = 3'd3,
    REST    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [31:0]   ram [DEPTH];
  logic [31:0]   env, env_n, env_sub, freq_n, entry;
  logic [32:0]   env_sum;
  logic [23:0]   tick, tick_n, step_last;
  logic [AW-1:0] idx_n, latch_idx;
  logic [AW:0]   eff_len, last_full;
  logic          wave_cur, wave_n, latch, last_step, step_end, loop_en, env_on;
  logic          busy_n, done_n;
  logic [31:0]   vsq_n, vsaw_n;

`ifdef SEQ_LOOP_EN
  assign loop_en = 1'b1;
`else
  assign loop_en = 1'b0;
`endif

  assign state_dbg = state;

  always_comb begin
    if (pattern_len == '0)                    eff_len = (AW+1)'(1);
    else if (pattern_len > (AW+1)'(DEPTH))    eff_len = (AW+1)'(DEPTH);
    else                                      eff_len = pattern_len;
  end

  // ">=" keeps a shortened pattern_len from letting the index run past the end.
  assign last_full = eff_len - (AW+1)'(1);
  assign last_step = {1'b0, step_index} >= last_full;
  assign step_last = (step_ticks == '0) ? '0 : step_ticks - 24'd1;
  assign step_end  = (tick == step_last);
  assign env_sub   = (env > release_dec) ? env - release_dec : '0;
  assign env_sum   = {1'b0, env} + {1'b0, attack_inc};

  // Priority inside active states: stop, then step end, then release point, then envelope.
  always_comb begin
    state_n   = state;
    env_n     = env;
    tick_n    = tick;
    idx_n     = step_index;
    freq_n    = frequency;
    wave_n    = wave_cur;
    latch     = 1'b0;
    latch_idx = '0;
    entry     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          tick_n = '0;
          idx_n  = '0;
          if (stop) begin
            state_n = DRAIN;
            env_n   = env_sub;
          end else begin
            latch = 1'b1;
          end
        end
      end
      DRAIN: begin
        env_n = env_sub;
        if (env_sub == '0) state_n = IDLE;
      end
      default: begin
        if (stop) begin
          state_n = DRAIN;
          env_n   = env_sub;
        end else if (step_end) begin
          tick_n = '0;
          if (last_step && !loop_en) begin
            state_n = DRAIN;
            env_n   = env_sub;
          end else begin
            latch     = 1'b1;
            latch_idx = last_step ? '0 : step_index + AW'(1);
          end
        end else begin
          tick_n = tick + 24'd1;
          if ((state == ATTACK || state == SUSTAIN) && tick == gate_ticks) begin
            state_n = RELEASE;
            env_n   = env_sub;
          end else if (state == ATTACK) begin
            if (env_sum >= {1'b0, max_volume}) begin
              env_n   = max_volume;
              state_n = SUSTAIN;
            end else begin
              env_n = env_sum[31:0];
            end
          end else if (state == RELEASE) begin
            env_n = env_sub;
          end else if (state == REST) begin
            env_n = '0;
          end
        end
      end
    endcase

    // Entry latch at step start; env carries over into ATTACK (legato), rests zero it.
    if (latch) begin
      idx_n  = latch_idx;
      entry  = ram[latch_idx];
      wave_n = wave_sel[latch_idx];
      if (entry != '0) begin
        freq_n  = entry;
        state_n = ATTACK;
      end else begin
        state_n = REST;
        env_n   = '0;
      end
    end
  end

  always_comb begin
    env_on = state_n inside {ATTACK, SUSTAIN, RELEASE, DRAIN};
    vsq_n  = (env_on &&  wave_n) ? env_n : '0;
    vsaw_n = (env_on && !wave_n) ? env_n : '0;
    busy_n = (state_n != IDLE);
    done_n = (state == DRAIN) && (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      env           <= '0;
      tick          <= '0;
      step_index    <= '0;
      frequency     <= RESET_FREQ;
      wave_cur      <= 1'b0;
      volume_square <= '0;
      volume_saw    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      env           <= env_n;
      tick          <= tick_n;
      step_index    <= idx_n;
      frequency     <= freq_n;
      wave_cur      <= wave_n;
      volume_square <= vsq_n;
      volume_saw    <= vsaw_n;
      busy          <= busy_n;
      done          <= done_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (cfg_we) begin
      ram[cfg_addr] <= cfg_data;
    end
  end

endmodule
